// File: rtl/magma_pkg.sv
// Shared types, command codes, payload sizes and GOST test vectors for the Magma frame loader.
package magma_pkg;

  localparam int KEY_BYTES = 32;
  localparam int BLK_BYTES = 8;

  localparam logic [7:0] CMD_KEY = 8'h4B;
  localparam logic [7:0] CMD_BLK = 8'h43;

  typedef enum logic [2:0] {
    IDLE,
    KEY,
    BLK,
    DROP,
    HOLD
  } state_t;

  // Reference vectors: ciphertext decrypts to plaintext under this key.
  localparam logic [255:0] TV_KEY =
    256'hffeeddccbbaa99887766554433221100f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
  localparam logic [63:0]  TV_CT  = 64'h4ee901e5c2d8ca3d;
  localparam logic [63:0]  TV_PT  = 64'hfedcba9876543210;

  function automatic logic [5:0] last_index(input int nbytes);
    return 6'(nbytes - 1);
  endfunction

endpackage

// File: rtl/magma_byte_packer.sv
// MSB-first byte shift register; 'shifted' previews the value with the current byte appended,
// so a commit on the final byte can capture the full payload in the same edge.
module magma_byte_packer #(
  parameter int NBYTES = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  load,
  input  logic [7:0]            data_byte,
  output logic [NBYTES*8-1:0]   shifted
);

  logic [NBYTES*8-1:0] shadow;

  assign shifted = {shadow[NBYTES*8-9:0], data_byte};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
    end else if (clr) begin
      shadow <= '0;
    end else if (load) begin
      shadow <= shifted;
    end
  end

endmodule

// File: rtl/magma_frame_loader.sv
// Decodes command-framed byte packets into an atomically committed key and a held ciphertext block.
// Commit is visible 1 cycle after the last payload byte; input is stalled while a block awaits ct_ready.
module magma_frame_loader
  import magma_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    in_byte,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [256:1]  key,
  output logic          key_loaded,
  output logic [64:1]   ciphertext,
  output logic          ct_valid,
  input  logic          ct_ready,
  output logic          err_cmd
);

  localparam logic [5:0] KEY_LAST = last_index(KEY_BYTES);
  localparam logic [5:0] BLK_LAST = last_index(BLK_BYTES);

  state_t       state;
  logic [5:0]   cnt;
  logic         accept;
  logic         key_start;
  logic         blk_start;
  logic [255:0] key_shifted;
  logic [63:0]  ct_shifted;

  assign accept    = in_valid && in_ready;
  assign key_start = accept && (state == IDLE) && (in_byte == CMD_KEY);
  assign blk_start = accept && (state == IDLE) && (in_byte == CMD_BLK) && key_loaded;

  magma_byte_packer #(.NBYTES(KEY_BYTES)) u_key_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (key_start),
    .load      (accept && (state == KEY)),
    .data_byte (in_byte),
    .shifted   (key_shifted)
  );

  magma_byte_packer #(.NBYTES(BLK_BYTES)) u_ct_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (blk_start),
    .load      (accept && (state == BLK)),
    .data_byte (in_byte),
    .shifted   (ct_shifted)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      in_ready   <= 1'b1;
      key        <= '0;
      key_loaded <= 1'b0;
      ciphertext <= '0;
      ct_valid   <= 1'b0;
      err_cmd    <= 1'b0;
    end else begin
      err_cmd <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            cnt <= '0;
            if (in_byte == CMD_KEY) begin
              state <= KEY;
            end else if (in_byte == CMD_BLK) begin
              // A block without a key is still framed, so swallow its payload.
              if (key_loaded) begin
                state <= BLK;
              end else begin
                state   <= DROP;
                err_cmd <= 1'b1;
              end
            end else begin
              err_cmd <= 1'b1;
            end
          end
        end
        KEY: begin
          if (accept) begin
            if (cnt == KEY_LAST) begin
              key        <= key_shifted;
              key_loaded <= 1'b1;
              cnt        <= '0;
              state      <= IDLE;
            end else begin
              cnt <= cnt + 6'd1;
            end
          end
        end
        BLK: begin
          if (accept) begin
            if (cnt == BLK_LAST) begin
              ciphertext <= ct_shifted;
              ct_valid   <= 1'b1;
              in_ready   <= 1'b0;
              cnt        <= '0;
              state      <= HOLD;
            end else begin
              cnt <= cnt + 6'd1;
            end
          end
        end
        DROP: begin
          if (accept) begin
            if (cnt == BLK_LAST) begin
              cnt   <= '0;
              state <= IDLE;
            end else begin
              cnt <= cnt + 6'd1;
            end
          end
        end
        HOLD: begin
          if (ct_ready) begin
            ct_valid <= 1'b0;
            in_ready <= 1'b1;
            state    <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
